// File: rtl/pet_action_scheduler.sv
// Serialises feed/heal/play/tick/test commands into single-cycle pulses for fsm_states,
// with edge detection, round-robin user arbitration, a decay tick and a post-command cooldown.
module pet_action_scheduler #(
   parameter int TICK_DIV = 10000,
   parameter int TICK_W   = 14,
   parameter int COOLDOWN = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_feed,
   input  logic       req_heal,
   input  logic       req_play,
   input  logic       req_test,
   input  logic       lights_off,
   output logic       feeding,
   output logic       healing,
   output logic       echo_sig,
   output logic       change_state,
   output logic       test,
   output logic       light_out,
   output logic [2:0] grant_id,
   output logic       busy
);
   localparam int CW = $clog2(COOLDOWN + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, COOL} state_e;

   state_e            state_q;
   logic [2:0]        req_q;        // {play, heal, feed}
   logic              test_req_q;
   logic [2:0]        pend_q, pend_d;
   logic              tick_pend_q, tick_pend_d;
   logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
   logic [1:0]        rr_q;
   logic [CW-1:0]     cool_q;
   logic              feeding_q, healing_q, echo_q, change_q, test_q, light_q;
   logic [2:0]        grant_q;

   logic [2:0] req_now, rise, sleep_mask, avail, clr;
   logic       test_rise, tick_wrap, grant_tick, grant_user, win_valid;
   logic [1:0] win_idx;

   assign req_now    = {req_play, req_heal, req_feed};
   assign rise       = req_now & ~req_q;
   assign test_rise  = req_test & ~test_req_q;
   // While dark only heal may be requested; feed/play are dropped, not deferred.
   assign sleep_mask = light_q ? 3'b010 : 3'b111;
   assign avail      = pend_q & sleep_mask;
   assign tick_wrap  = (tick_cnt_q == TICK_W'(TICK_DIV - 1));

   // Round-robin search starting at the pointer: feed -> heal -> play -> feed.
   always_comb begin
      win_valid = 1'b0;
      win_idx   = rr_q;
      for (int i = 0; i < 3; i++) begin
         int k;
         k = int'(rr_q) + i;
         if (k >= 3) k = k - 3;
         if (!win_valid && avail[k]) begin
            win_valid = 1'b1;
            win_idx   = 2'(k);
         end
      end
   end

   assign grant_tick = (state_q == IDLE) && tick_pend_q;
   assign grant_user = (state_q == IDLE) && !tick_pend_q && win_valid;
   assign clr        = grant_user ? (3'b001 << win_idx) : 3'b000;

   // A new edge in the same cycle as its grant keeps the request pending.
   always_comb begin
      pend_d      = ((pend_q & ~clr) | rise) & sleep_mask;
      tick_pend_d = (tick_pend_q & ~grant_tick) | tick_wrap;
      tick_cnt_d  = tick_wrap ? '0 : tick_cnt_q + TICK_W'(1);
      if (test_rise) begin
         pend_d      = '0;
         tick_pend_d = 1'b0;
         tick_cnt_d  = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         req_q       <= '0;
         test_req_q  <= 1'b0;
         pend_q      <= '0;
         tick_pend_q <= 1'b0;
         tick_cnt_q  <= '0;
         light_q     <= 1'b0;
      end else begin
         req_q       <= req_now;
         test_req_q  <= req_test;
         pend_q      <= pend_d;
         tick_pend_q <= tick_pend_d;
         tick_cnt_q  <= tick_cnt_d;
         light_q     <= lights_off;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         rr_q      <= 2'd0;
         cool_q    <= '0;
         feeding_q <= 1'b0;
         healing_q <= 1'b0;
         echo_q    <= 1'b0;
         change_q  <= 1'b0;
         test_q    <= 1'b0;
         grant_q   <= 3'd0;
      end else if (test_rise) begin
         // Test preempts everything, including a pulse currently high.
         state_q   <= ISSUE;
         rr_q      <= 2'd0;
         feeding_q <= 1'b0;
         healing_q <= 1'b0;
         echo_q    <= 1'b0;
         change_q  <= 1'b0;
         test_q    <= 1'b1;
         grant_q   <= 3'd5;
      end else begin
         case (state_q)
            IDLE: begin
               if (tick_pend_q) begin
                  change_q <= 1'b1;
                  grant_q  <= 3'd4;
                  state_q  <= ISSUE;
               end else if (win_valid) begin
                  feeding_q <= (win_idx == 2'd0);
                  healing_q <= (win_idx == 2'd1);
                  echo_q    <= (win_idx == 2'd2);
                  grant_q   <= {1'b0, win_idx} + 3'd1;
                  rr_q      <= (win_idx == 2'd2) ? 2'd0 : win_idx + 2'd1;
                  state_q   <= ISSUE;
               end else begin
                  grant_q <= 3'd0;
               end
            end
            ISSUE: begin
               feeding_q <= 1'b0;
               healing_q <= 1'b0;
               echo_q    <= 1'b0;
               change_q  <= 1'b0;
               test_q    <= 1'b0;
               cool_q    <= CW'(COOLDOWN);
               state_q   <= COOL;
            end
            COOL: begin
               cool_q <= cool_q - CW'(1);
               if (cool_q == CW'(1)) begin
                  state_q <= IDLE;
                  grant_q <= 3'd0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign feeding      = feeding_q;
   assign healing      = healing_q;
   assign echo_sig     = echo_q;
   assign change_state = change_q;
   assign test         = test_q;
   assign light_out    = light_q;
   assign grant_id     = grant_q;
   assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_pet_action_scheduler.sv
// Scoreboard bench for pet_action_scheduler: each scenario queues the pulses it expects
// (kind + cycle) and a negedge monitor pops and compares every pulse the DUT emits.
module tb_pet_action_scheduler;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       req_feed = 1'b0, req_heal = 1'b0, req_play = 1'b0, req_test = 1'b0, lights_off = 1'b0;
   logic       feeding, healing, echo_sig, change_state, test, light_out, busy;
   logic [2:0] grant_id;

   typedef struct { int kind; int cyc; } exp_t;
   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc;
   bit   mon_en = 1'b0;

   pet_action_scheduler #(.TICK_DIV(20), .TICK_W(5), .COOLDOWN(2)) dut (
      .clk(clk), .rst(rst), .req_feed(req_feed), .req_heal(req_heal), .req_play(req_play),
      .req_test(req_test), .lights_off(lights_off), .feeding(feeding), .healing(healing),
      .echo_sig(echo_sig), .change_state(change_state), .test(test), .light_out(light_out),
      .grant_id(grant_id), .busy(busy)
   );

   always #5 clk = ~clk;

   // cyc = number of rising edges since reset release
   always @(posedge clk or negedge rst)
      if (!rst) cyc <= 0;
      else      cyc <= cyc + 1;

   always @(negedge clk) begin
      logic [4:0] p;
      int kind;
      p = {test, change_state, echo_sig, healing, feeding};
      if (mon_en && rst && p != 5'b0) begin
         total++;
         if ($countones(p) != 1) begin
            bad++;
            $display("FAIL onehot cyc=%0d pulses=%b want exactly one", cyc, p);
         end
         kind = 0;
         for (int i = 0; i < 5; i++) if (p[i]) kind = i + 1;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_pulse cyc=%0d kind=%0d want none", cyc, kind);
         end else begin
            exp_t e;
            e = sb.pop_front();
            total++;
            if (kind !== e.kind || cyc !== e.cyc) begin
               bad++;
               $display("FAIL pulse got kind=%0d cyc=%0d want kind=%0d cyc=%0d", kind, cyc, e.kind, e.cyc);
            end
            total++;
            if (grant_id !== 3'(e.kind)) begin
               bad++;
               $display("FAIL grant_id cyc=%0d got=%0d want=%0d", cyc, grant_id, e.kind);
            end
         end
      end
   end

   task automatic wait_to(input int n);
      do @(negedge clk); while (cyc < n);
   endtask

   task automatic expect_pulse(input int kind, input int c);
      exp_t e;
      e.kind = kind;
      e.cyc  = c;
      sb.push_back(e);
   endtask

   task automatic do_reset();
      mon_en = 1'b0;
      rst = 1'b0;
      {req_feed, req_heal, req_play, req_test, lights_off} = '0;
      sb.delete();
      repeat (3) @(negedge clk);
      rst = 1'b1;
      mon_en = 1'b1;
   endtask

   task automatic drain_check(input string name);
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL %s_missing pending=%0d want 0 (next kind=%0d cyc=%0d)",
                  name, sb.size(), sb[0].kind, sb[0].cyc);
         sb.delete();
      end
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      total++;
      if ({feeding, healing, echo_sig, change_state, test, light_out, busy, grant_id} !== 10'b0) begin
         bad++;
         $display("FAIL reset_outputs got=%b want 0", {feeding, healing, echo_sig, change_state, test, light_out, busy, grant_id});
      end
      expect_pulse(4, 21);
      wait_to(24);
      drain_check("first_tick");
      req_feed = 1'b1;
      expect_pulse(1, 26);
      wait_to(26);
      #2 rst = 1'b0;
      #1;
      total++;
      if ({feeding, healing, echo_sig, change_state, test, busy, grant_id} !== 9'b0) begin
         bad++;
         $display("FAIL async_reset got=%b want 0", {feeding, healing, echo_sig, change_state, test, busy, grant_id});
      end
      req_feed = 1'b0;
      drain_check("pre_reset_feed");
   endtask

   task automatic test_single_feed();
      do_reset();
      wait_to(2);
      req_feed = 1'b1;
      expect_pulse(1, 4);
      wait_to(4);
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL feed_busy got=%b want 1", busy);
      end
      wait_to(8);
      total++;
      if ({busy, grant_id} !== 4'b0) begin
         bad++;
         $display("FAIL feed_idle got busy=%b grant=%0d want 0/0", busy, grant_id);
      end
      wait_to(12);
      req_feed = 1'b0;
      wait_to(15);
      drain_check("single_feed");
   endtask

   task automatic test_simultaneous();
      do_reset();
      wait_to(2);
      {req_feed, req_heal, req_play} = 3'b111;
      expect_pulse(1, 4);
      expect_pulse(2, 8);
      expect_pulse(3, 12);
      wait_to(5);
      {req_feed, req_heal, req_play} = 3'b000;
      wait_to(16);
      drain_check("simultaneous");
   endtask

   task automatic test_round_robin();
      do_reset();
      wait_to(2);
      req_feed = 1'b1;
      expect_pulse(1, 4);
      wait_to(3);
      req_feed = 1'b0;
      wait_to(8);
      // pointer now at heal, so heal beats feed
      {req_feed, req_heal} = 2'b11;
      expect_pulse(2, 10);
      expect_pulse(1, 14);
      wait_to(11);
      {req_feed, req_heal} = 2'b00;
      wait_to(18);
      drain_check("round_robin");
   endtask

   task automatic test_tick_priority();
      do_reset();
      wait_to(19);
      req_heal = 1'b1;
      expect_pulse(4, 21);
      expect_pulse(2, 25);
      wait_to(22);
      req_heal = 1'b0;
      wait_to(29);
      drain_check("tick_priority");
   endtask

   task automatic test_sleep();
      do_reset();
      wait_to(1);
      lights_off = 1'b1;
      total++;
      if (light_out !== 1'b0) begin
         bad++;
         $display("FAIL light_delay got=%b want 0", light_out);
      end
      wait_to(2);
      total++;
      if (light_out !== 1'b1) begin
         bad++;
         $display("FAIL light_out got=%b want 1", light_out);
      end
      wait_to(3);
      {req_feed, req_play} = 2'b11;
      wait_to(6);
      req_heal = 1'b1;
      expect_pulse(2, 8);
      wait_to(10);
      {req_feed, req_heal, req_play} = 3'b000;
      wait_to(12);
      lights_off = 1'b0;
      wait_to(14);
      req_feed = 1'b1;
      expect_pulse(1, 16);
      wait_to(17);
      req_feed = 1'b0;
      wait_to(20);
      drain_check("sleep");
   endtask

   task automatic test_test_cmd();
      do_reset();
      wait_to(2);
      req_feed = 1'b1;
      expect_pulse(1, 4);
      wait_to(3);
      req_feed = 1'b0;
      wait_to(5);
      req_feed = 1'b1;
      wait_to(6);
      req_test = 1'b1;
      expect_pulse(5, 7);
      expect_pulse(4, 28);
      wait_to(8);
      {req_feed, req_test} = 2'b00;
      wait_to(31);
      drain_check("test_cmd");
   endtask

   initial begin
      test_reset();
      test_single_feed();
      test_simultaneous();
      test_round_robin();
      test_tick_priority();
      test_sleep();
      test_test_cmd();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
